spi_master_arb: RTL and testbench

Two-port SPI master that shares one SPI bus between two on-chip requesters and sequences full-frame transfers to the team's M-bit SPI slave. Grants are round-robin; each grant runs one complete frame (SS low, M SCLK cycles MSB-first, SS high), returns the received word to the granted requester and enforces an SS-high gap before the next frame. It sits between system logic on GCLK and the off-block SPI pins.

---
 rtl/spi_master_arb.sv | 173 +++++++++++++++++
 tb/tb_spi_master_arb.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_arb.sv
// Two-requester SPI master: round-robin grants, one full mode-0 frame per grant,
// received word returned to the granted requester, then an SS-high gap.
module spi_master_arb #(
  parameter int M      = 15,
  parameter int CLKDIV = 4,
  parameter int SS_GAP = 2
) (
  input  logic         GCLK,
  input  logic         RST_N,
  input  logic         REQ0,
  input  logic         REQ1,
  input  logic [M-1:0] DIN0,
  input  logic [M-1:0] DIN1,
  output logic         DONE0,
  output logic         DONE1,
  output logic [M-1:0] DOUT0,
  output logic [M-1:0] DOUT1,
  output logic         BUSY,
  output logic         SCLK,
  output logic         SS,
  output logic         MOSI,
  input  logic         MISO
);

  localparam int CMAX = (CLKDIV > SS_GAP) ? CLKDIV : SS_GAP;
  localparam int CW   = $clog2(CMAX);
  localparam int BW   = $clog2(M + 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(CLKDIV - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(SS_GAP - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(M - 1);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_HOLD, S_GAP} state_t;

  state_t         r_state, w_next_state;
  logic [CW-1:0]  r_cnt;
  logic [BW-1:0]  r_bits;
  logic [M-1:0]   r_tx, r_rx, r_dout0, r_dout1;
  logic           r_sclk, r_ss, r_mosi, r_busy, r_done0, r_done1;
  logic           r_gnt, r_last;

  logic           w_any_req, w_gnt_idx, w_wrap;
  logic           w_grant, w_rise, w_fall, w_last_fall, w_hold_end, w_gap_end;
  logic [M-1:0]   w_din_sel;

  assign w_any_req = REQ0 | REQ1;
  // With both requesting, the side that was not served last wins.
  assign w_gnt_idx = (REQ0 & REQ1) ? ~r_last : REQ1;
  assign w_din_sel = w_gnt_idx ? DIN1 : DIN0;
  assign w_wrap    = (r_cnt == DIV_LAST);

  // NOTE: non-blocking (<=) for every clocked register so all flops update
  // together from pre-edge values, independent of statement order.
  always_ff @(posedge GCLK or negedge RST_N) begin
    if (!RST_N) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  // NOTE: every comb output gets a default first; a path that leaves one
  // unassigned would infer a latch.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_grant)     w_next_state = S_SHIFT;
      S_SHIFT: if (w_last_fall) w_next_state = S_HOLD;
      S_HOLD:  if (w_hold_end)  w_next_state = S_GAP;
      S_GAP:   if (w_gap_end)   w_next_state = w_grant ? S_SHIFT : S_IDLE;
      default:                  w_next_state = S_IDLE;
    endcase
  end

  // The GAP exit edge arbitrates like IDLE, so a waiting request is granted
  // on the same edge BUSY would otherwise fall.
  always_comb begin
    w_grant     = 1'b0;
    w_rise      = 1'b0;
    w_fall      = 1'b0;
    w_last_fall = 1'b0;
    w_hold_end  = 1'b0;
    w_gap_end   = 1'b0;
    case (r_state)
      S_IDLE:  w_grant = w_any_req;
      S_SHIFT: begin
        w_rise      = w_wrap & ~r_sclk;
        w_fall      = w_wrap &  r_sclk;
        w_last_fall = w_wrap &  r_sclk & (r_bits == BIT_LAST);
      end
      S_HOLD:  w_hold_end = w_wrap;
      S_GAP: begin
        w_gap_end = (r_cnt == GAP_LAST);
        w_grant   = w_gap_end & w_any_req;
      end
      default: ;
    endcase
  end

  always_ff @(posedge GCLK or negedge RST_N) begin
    if (!RST_N) begin
      r_cnt   <= '0;
      r_bits  <= '0;
      r_tx    <= '0;
      r_rx    <= '0;
      r_dout0 <= '0;
      r_dout1 <= '0;
      r_sclk  <= 1'b0;
      r_ss    <= 1'b1;
      r_mosi  <= 1'b0;
      r_busy  <= 1'b0;
      r_done0 <= 1'b0;
      r_done1 <= 1'b0;
      r_gnt   <= 1'b0;
      r_last  <= 1'b1;
    end else begin
      r_done0 <= 1'b0;
      r_done1 <= 1'b0;
      if (w_grant) begin
        r_tx   <= w_din_sel;
        r_mosi <= w_din_sel[M-1];
        r_gnt  <= w_gnt_idx;
        r_last <= w_gnt_idx;
        r_ss   <= 1'b0;
        r_sclk <= 1'b0;
        r_busy <= 1'b1;
        r_cnt  <= '0;
        r_bits <= '0;
      end else begin
        case (r_state)
          S_SHIFT: begin
            r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;
            if (w_wrap) r_sclk <= ~r_sclk;
            if (w_rise) r_rx <= {r_rx[M-2:0], MISO};
            if (w_fall) begin
              r_bits <= r_bits + 1'b1;
              if (w_last_fall) begin
                r_mosi <= 1'b0;
              end else begin
                r_tx   <= r_tx << 1;
                r_mosi <= r_tx[M-2];
              end
            end
          end
          S_HOLD: begin
            r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;
            if (w_hold_end) begin
              r_ss <= 1'b1;
              if (r_gnt) begin
                r_dout1 <= r_rx;
                r_done1 <= 1'b1;
              end else begin
                r_dout0 <= r_rx;
                r_done0 <= 1'b1;
              end
            end
          end
          S_GAP: begin
            r_cnt <= w_gap_end ? '0 : r_cnt + 1'b1;
            if (w_gap_end) r_busy <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

  assign SCLK  = r_sclk;
  assign SS    = r_ss;
  assign MOSI  = r_mosi;
  assign BUSY  = r_busy;
  assign DONE0 = r_done0;
  assign DONE1 = r_done1;
  assign DOUT0 = r_dout0;
  assign DOUT1 = r_dout1;

endmodule

// File: tb/tb_spi_master_arb.sv
// Bench for spi_master_arb: a frame-timing model derived from the bit/edge
// formulas is compared every cycle, plus directed scenario checks.
module tb_spi_master_arb;

  localparam int M      = 15;
  localparam int C      = 4;
  localparam int G      = 2;
  localparam int SH_D   = 2 * M * C;          // last SCLK fall offset
  localparam int DONE_D = (2 * M + 1) * C;    // SS rise / DONE offset
  localparam int END_D  = DONE_D + G;         // BUSY fall / next grant offset

  logic         GCLK = 1'b0;
  logic         RST_N;
  logic         REQ0, REQ1;
  logic [M-1:0] DIN0, DIN1;
  logic         DONE0, DONE1;
  logic [M-1:0] DOUT0, DOUT1;
  logic         BUSY, SCLK, SS, MOSI, MISO;

  logic         loop_mode;
  logic [M-1:0] slave_din;

  spi_master_arb #(.M(M), .CLKDIV(C), .SS_GAP(G)) dut (
    .GCLK(GCLK), .RST_N(RST_N), .REQ0(REQ0), .REQ1(REQ1),
    .DIN0(DIN0), .DIN1(DIN1), .DONE0(DONE0), .DONE1(DONE1),
    .DOUT0(DOUT0), .DOUT1(DOUT1), .BUSY(BUSY), .SCLK(SCLK),
    .SS(SS), .MOSI(MOSI), .MISO(MISO)
  );

  always #5 GCLK = ~GCLK;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge GCLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Mode-0 SPI slave: MSB out on SS fall, sample on SCLK rise, shift on fall.
  logic [M-1:0] s_sh = '0, s_rx = '0, s_dout = '0;
  logic         s_miso = 1'b0;
  always @(negedge SS) begin
    s_sh   <= slave_din;
    s_miso <= slave_din[M-1];
  end
  always @(posedge SCLK) s_rx <= {s_rx[M-2:0], MOSI};
  always @(negedge SCLK) if (!SS) begin
    s_sh   <= s_sh << 1;
    s_miso <= s_sh[M-2];
  end
  always @(posedge SS) s_dout <= s_rx;

  assign MISO = loop_mode ? MOSI : s_miso;

  // Model: frame position m_d (GCLK edges since grant) fully determines pins.
  bit           m_act = 0, m_last = 1, m_idx = 0, m_done0 = 0, m_done1 = 0;
  int           m_d = 0;
  logic [M-1:0] m_word = '0, m_rx = '0, m_dout0 = '0, m_dout1 = '0;

  always @(posedge GCLK or negedge RST_N) begin : model
    bit act, idx, last, d0, d1;
    int d;
    logic [M-1:0] word, rx, o0, o1;
    if (!RST_N) begin
      m_act <= 0; m_d <= 0; m_last <= 1; m_done0 <= 0; m_done1 <= 0;
      m_dout0 <= '0; m_dout1 <= '0;
    end else begin
      act = m_act; d = m_d; idx = m_idx; last = m_last;
      word = m_word; rx = m_rx; o0 = m_dout0; o1 = m_dout1;
      d0 = 0; d1 = 0;
      if (act) begin
        d = d + 1;
        if (d == END_D) act = 0;
      end
      if (act && d == DONE_D) begin
        if (idx) begin o1 = rx; d1 = 1; end
        else     begin o0 = rx; d0 = 1; end
      end
      if (!act && (REQ0 || REQ1)) begin
        idx  = (REQ0 && REQ1) ? !last : REQ1;
        last = idx;
        word = idx ? DIN1 : DIN0;
        rx   = loop_mode ? word : slave_din;
        act  = 1;
        d    = 0;
      end
      m_act <= act; m_d <= d; m_idx <= idx; m_last <= last;
      m_word <= word; m_rx <= rx; m_dout0 <= o0; m_dout1 <= o1;
      m_done0 <= d0; m_done1 <= d1;
    end
  end

  function automatic logic [5:0] exp_ctrl();
    logic e_ss, e_sclk, e_mosi;
    e_ss   = !(m_act && m_d < DONE_D);
    e_sclk = m_act && m_d < SH_D && ((m_d / C) % 2 == 1);
    e_mosi = (m_act && m_d < SH_D) ? m_word[M-1 - m_d / (2 * C)] : 1'b0;
    return {m_act, e_ss, e_sclk, e_mosi, m_done0, m_done1};
  endfunction

  always @(negedge GCLK) begin
    check("cyc_ctrl{busy,ss,sclk,mosi,done0,done1}",
          {BUSY, SS, SCLK, MOSI, DONE0, DONE1}, exp_ctrl());
    check("cyc_dout{dout0,dout1}", {DOUT0, DOUT1}, {m_dout0, m_dout1});
  end

  // Pin monitor giving measured timing for the literal checks.
  logic prev_ss = 1'b1, prev_sclk = 1'b0;
  int   t0 = 0, last_gap = 0, ss_rise_cyc = 0, rises = 0, per_bad = 0;
  int   last_rise = 0, done_cyc = 0, done0_cnt = 0, done1_cnt = 0;
  int   t0_q[$], done_q[$];

  always @(negedge GCLK) begin
    prev_ss   <= SS;
    prev_sclk <= SCLK;
    if (prev_ss && !SS) begin
      t0 <= cyc;
      t0_q.push_back(cyc);
      last_gap <= cyc - ss_rise_cyc;
      rises <= 0;
      per_bad <= 0;
    end else if (!prev_sclk && SCLK) begin
      rises <= rises + 1;
      if (rises > 0 && cyc - last_rise != 2 * C) per_bad <= per_bad + 1;
      last_rise <= cyc;
    end
    if (!prev_ss && SS) ss_rise_cyc <= cyc;
    if (DONE0) begin done_q.push_back(0); done_cyc <= cyc; done0_cnt <= done0_cnt + 1; end
    if (DONE1) begin done_q.push_back(1); done_cyc <= cyc; done1_cnt <= done1_cnt + 1; end
  end

  task automatic wait_done(input int which, input int budget);
    int n = 0;
    bit hit = 0;
    while (!hit && n < budget) begin
      @(negedge GCLK);
      n++;
      hit = (which == 0) ? (DONE0 === 1'b1) : (DONE1 === 1'b1);
    end
    check($sformatf("wait_done%0d_timeout", which), hit, 1'b1);
    #1;
  endtask

  task automatic wait_any_done(input int budget);
    int n = 0;
    bit hit = 0;
    while (!hit && n < budget) begin
      @(negedge GCLK);
      n++;
      hit = (DONE0 === 1'b1) || (DONE1 === 1'b1);
    end
    check("wait_any_done_timeout", hit, 1'b1);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int tg, d0_before;
    RST_N = 1'b0; REQ0 = 0; REQ1 = 0; DIN0 = '0; DIN1 = '0;
    loop_mode = 1'b1; slave_din = '0;
    repeat (3) @(negedge GCLK);
    #1;
    check("reset_ctrl{sclk,ss,mosi,busy,done0,done1}",
          {SCLK, SS, MOSI, BUSY, DONE0, DONE1}, 6'b010000);
    check("reset_dout", {DOUT0, DOUT1}, 30'h0);
    @(negedge GCLK); RST_N = 1'b1;
    repeat (2) @(negedge GCLK);

    // Loopback, requester 0.
    DIN0 = 15'h2AAA; REQ0 = 1;
    wait_done(0, 300); REQ0 = 0;
    check("t1_done_latency", done_cyc - t0, 124);
    check("t1_sclk_rises", rises, 15);
    check("t1_sclk_period_errs", per_bad, 0);
    check("t1_dout0", DOUT0, 15'h2AAA);
    repeat (4) @(negedge GCLK);
    check("t1_no_done1", done1_cnt, 0);

    // Against the slave, requester 1.
    loop_mode = 0; slave_din = 15'h1234; DIN1 = 15'h0F0F; REQ1 = 1;
    wait_done(1, 300); REQ1 = 0;
    check("t2_dout1", DOUT1, 15'h1234);
    repeat (3) @(negedge GCLK);
    check("t2_slave_dout", s_dout, 15'h0F0F);
    loop_mode = 1;

    // Fresh reset, both request in the same cycle.
    RST_N = 0; @(negedge GCLK); RST_N = 1; @(negedge GCLK);
    t0_q.delete(); done_q.delete();
    DIN0 = 15'h1111; DIN1 = 15'h6666; REQ0 = 1; REQ1 = 1;
    wait_done(0, 300); REQ0 = 0;
    wait_done(1, 300); REQ1 = 0;
    check("t3_n_done", done_q.size(), 2);
    check("t3_first_served", done_q[0], 0);
    check("t3_second_served", done_q[1], 1);
    check("t3_grant_spacing", t0_q[1] - t0_q[0], 126);
    check("t3_ss_gap", last_gap, 2);
    check("t3_douts", {DOUT0, DOUT1}, {15'h1111, 15'h6666});

    // Both held for four frames.
    repeat (4) @(negedge GCLK);
    t0_q.delete(); done_q.delete();
    DIN0 = 15'h0055; DIN1 = 15'h7F00; REQ0 = 1; REQ1 = 1;
    for (int i = 0; i < 4; i++) wait_any_done(300);
    REQ0 = 0; REQ1 = 0;
    check("t4_n_done", done_q.size(), 4);
    for (int i = 0; i < 4; i++) check($sformatf("t4_order%0d", i), done_q[i], i % 2);
    for (int i = 0; i < 3; i++) check($sformatf("t4_spacing%0d", i), t0_q[i+1] - t0_q[i], 126);

    // Reset pulsed mid-frame at T0+50.
    repeat (4) @(negedge GCLK);
    DIN0 = 15'h5A5A; REQ0 = 1;
    tg = cyc + 1;
    repeat (51) @(negedge GCLK);
    check("t5_at_t0_plus_50", cyc - tg, 50);
    check("t5_midframe_busy_ss", {BUSY, SS}, 2'b10);
    #1 RST_N = 0;
    #1;
    check("t5_async_reset_pins{ss,sclk,mosi,busy}", {SS, SCLK, MOSI, BUSY}, 4'b1000);
    check("t5_async_reset_dout0", DOUT0, 15'h0);
    REQ0 = 0;
    @(negedge GCLK); RST_N = 1;
    d0_before = done0_cnt;
    repeat (130) @(negedge GCLK);
    #1;
    check("t5_no_done_after_abort", done0_cnt - d0_before, 0);
    DIN0 = 15'h1357; REQ0 = 1;
    wait_done(0, 300); REQ0 = 0;
    check("t5_post_reset_dout0", DOUT0, 15'h1357);
    check("t5_post_reset_rises", rises, 15);

    // REQ0 dropped and DIN0 changed mid-frame.
    repeat (4) @(negedge GCLK);
    DIN0 = 15'h4321; REQ0 = 1;
    @(negedge GCLK);
    DIN0 = 15'h7ABC;
    repeat (9) @(negedge GCLK);
    REQ0 = 0;
    wait_done(0, 300);
    check("t6_dout0_latched", DOUT0, 15'h4321);
    check("t6_done_latency", done_cyc - t0, 124);

    repeat (4) @(negedge GCLK);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
